// File: rtl/rambus_arbiter.sv
// rambus_arbiter
// --------------
// Two-master round-robin arbiter in front of the RAMBus pattern RAM controller.
// The Caravel host uses a 1 KiB byte-addressed window at BASE_ADDRESS. The
// waveform generator fetch port uses 8-bit word addresses. The arbiter carries
// one transaction at a time to the single RAMBus Wishbone slave.
//
// Ports
//   caravel_wb_clk_i / caravel_wb_rst_n_i : clock, synchronous active-low reset
//   caravel_wb_*  : host slave port (byte address, registered ack/dat_o)
//   gen_wb_*      : generator slave port (word address, registered ack/dat_o)
//   rambus_wb_*   : master port to the RAMBus controller (registered request)
//   grant_o       : current/last owner, 0 = generator, 1 = host
//   timeout_err_o : sticky flag, set when a granted transaction was never acked
//   arb_state_o   : FSM state (0 = IDLE, 1 = BUSY, 2 = DONE), for observation
//
// Handshake: a master request is taken only in IDLE, when stb & cyc (and, for
// the host, an in-window address) are high at a clock edge. The master must
// hold its request until it sees its ack, which is high for exactly one cycle.
// The rambus request stays stable from grant until rambus_wb_ack_i. The
// following DONE cycle gives the master time to drop or change its request.
//
// Optional feature: define RAMBUS_ARB_TIMEOUT_EN to build the ack timeout.
// A transaction that receives no ack within TIMEOUT BUSY cycles is then
// completed with read data 0, and timeout_err_o is set.
module rambus_arbiter #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_1000,
  parameter logic [7:0]  TIMEOUT      = 8'd255
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_n_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_dat_i,
  input  logic [31:0] caravel_wb_addr_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o,
  input  logic        gen_wb_stb_i,
  input  logic        gen_wb_cyc_i,
  input  logic        gen_wb_we_i,
  input  logic [3:0]  gen_wb_sel_i,
  input  logic [31:0] gen_wb_dat_i,
  input  logic [7:0]  gen_wb_addr_i,
  output logic        gen_wb_ack_o,
  output logic [31:0] gen_wb_dat_o,
  output logic        rambus_wb_clk_o,
  output logic        rambus_wb_rst_o,
  output logic        rambus_wb_stb_o,
  output logic        rambus_wb_cyc_o,
  output logic        rambus_wb_we_o,
  output logic [3:0]  rambus_wb_sel_o,
  output logic [31:0] rambus_wb_dat_o,
  output logic [7:0]  rambus_wb_addr_o,
  input  logic        rambus_wb_ack_i,
  input  logic [31:0] rambus_wb_dat_i,
  output logic        grant_o,
  output logic        timeout_err_o,
  output logic [1:0]  arb_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   last;       // owner of the previous grant, 1 = host
  logic   host_req;
  logic   gen_req;
  logic   pick_host;

  // The byte lane bits of the host address never reach the word-addressed RAM.
  logic   unused_host_addr_bits;
  assign unused_host_addr_bits = &{1'b0, caravel_wb_addr_i[1:0]};

  assign rambus_wb_clk_o = caravel_wb_clk_i;
  assign rambus_wb_rst_o = ~caravel_wb_rst_n_i;
  assign arb_state_o     = state;

  assign host_req = caravel_wb_stb_i & caravel_wb_cyc_i &
                    (caravel_wb_addr_i[31:10] == BASE_ADDRESS[31:10]);
  assign gen_req  = gen_wb_stb_i & gen_wb_cyc_i;

  // On a tie the grant goes to the master that did not own the previous grant.
  assign pick_host = host_req & (~gen_req | ~last);

`ifdef RAMBUS_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;
`else
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge caravel_wb_clk_i) begin
    if (!caravel_wb_rst_n_i) begin
      state            <= IDLE;
      last             <= 1'b1;
      grant_o          <= 1'b0;
      rambus_wb_stb_o  <= 1'b0;
      rambus_wb_cyc_o  <= 1'b0;
      rambus_wb_we_o   <= 1'b0;
      rambus_wb_sel_o  <= 4'hF;
      rambus_wb_dat_o  <= 32'h0;
      rambus_wb_addr_o <= 8'h0;
      caravel_wb_ack_o <= 1'b0;
      caravel_wb_dat_o <= 32'h0;
      gen_wb_ack_o     <= 1'b0;
      gen_wb_dat_o     <= 32'h0;
`ifdef RAMBUS_ARB_TIMEOUT_EN
      to_cnt           <= 8'h0;
      timeout_err_o    <= 1'b0;
`endif
    end else begin
      // Master acks are single-cycle pulses.
      caravel_wb_ack_o <= 1'b0;
      gen_wb_ack_o     <= 1'b0;

      case (state)
        IDLE: begin
          if (host_req || gen_req) begin
            grant_o          <= pick_host;
            last             <= pick_host;
            rambus_wb_stb_o  <= 1'b1;
            rambus_wb_cyc_o  <= 1'b1;
            rambus_wb_we_o   <= pick_host ? caravel_wb_we_i  : gen_wb_we_i;
            rambus_wb_sel_o  <= pick_host ? caravel_wb_sel_i : gen_wb_sel_i;
            rambus_wb_dat_o  <= pick_host ? caravel_wb_dat_i : gen_wb_dat_i;
            rambus_wb_addr_o <= pick_host ? caravel_wb_addr_i[9:2] : gen_wb_addr_i;
            state            <= BUSY;
`ifdef RAMBUS_ARB_TIMEOUT_EN
            to_cnt           <= 8'h0;
`endif
          end
        end

        BUSY: begin
          // An ack in the same cycle as expiry wins: it is tested first.
          if (rambus_wb_ack_i) begin
            rambus_wb_stb_o <= 1'b0;
            rambus_wb_cyc_o <= 1'b0;
            if (grant_o) begin
              caravel_wb_ack_o <= 1'b1;
              caravel_wb_dat_o <= rambus_wb_dat_i;
            end else begin
              gen_wb_ack_o <= 1'b1;
              gen_wb_dat_o <= rambus_wb_dat_i;
            end
            state <= DONE;
          end
`ifdef RAMBUS_ARB_TIMEOUT_EN
          else if (to_cnt >= TIMEOUT - 8'd1) begin
            rambus_wb_stb_o <= 1'b0;
            rambus_wb_cyc_o <= 1'b0;
            timeout_err_o   <= 1'b1;
            if (grant_o) begin
              caravel_wb_ack_o <= 1'b1;
              caravel_wb_dat_o <= 32'h0;
            end else begin
              gen_wb_ack_o <= 1'b1;
              gen_wb_dat_o <= 32'h0;
            end
            state <= DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end

        DONE: begin
          // Requests are not sampled here, so the acked master can drop stb.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed testbench for rambus_arbiter: a RAM model with programmable ack
// wait, a grant monitor feeding an observed-grant queue, and a linear sequence
// of directed steps whose expected values are worked out by hand.
module tb_rambus_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        h_stb, h_cyc, h_we;
  logic [3:0]  h_sel;
  logic [31:0] h_dat, h_addr;
  logic        h_ack;
  logic [31:0] h_rdat;
  logic        g_stb, g_cyc, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_dat;
  logic [7:0]  g_addr;
  logic        g_ack;
  logic [31:0] g_rdat;
  logic        r_clk, r_rst, r_stb, r_cyc, r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic [7:0]  r_addr;
  logic        ram_ack;
  logic [31:0] ram_rdat;
  logic        grant, terr;
  logic [1:0]  st;

  int checks   = 0;
  int failures = 0;

  rambus_arbiter #(.BASE_ADDRESS(32'h3000_1000), .TIMEOUT(8'd4)) dut (
    .caravel_wb_clk_i   (clk),
    .caravel_wb_rst_n_i (rst_n),
    .caravel_wb_stb_i   (h_stb),
    .caravel_wb_cyc_i   (h_cyc),
    .caravel_wb_we_i    (h_we),
    .caravel_wb_sel_i   (h_sel),
    .caravel_wb_dat_i   (h_dat),
    .caravel_wb_addr_i  (h_addr),
    .caravel_wb_ack_o   (h_ack),
    .caravel_wb_dat_o   (h_rdat),
    .gen_wb_stb_i       (g_stb),
    .gen_wb_cyc_i       (g_cyc),
    .gen_wb_we_i        (g_we),
    .gen_wb_sel_i       (g_sel),
    .gen_wb_dat_i       (g_dat),
    .gen_wb_addr_i      (g_addr),
    .gen_wb_ack_o       (g_ack),
    .gen_wb_dat_o       (g_rdat),
    .rambus_wb_clk_o    (r_clk),
    .rambus_wb_rst_o    (r_rst),
    .rambus_wb_stb_o    (r_stb),
    .rambus_wb_cyc_o    (r_cyc),
    .rambus_wb_we_o     (r_we),
    .rambus_wb_sel_o    (r_sel),
    .rambus_wb_dat_o    (r_dat),
    .rambus_wb_addr_o   (r_addr),
    .rambus_wb_ack_i    (ram_ack),
    .rambus_wb_dat_i    (ram_rdat),
    .grant_o            (grant),
    .timeout_err_o      (terr),
    .arb_state_o        (st)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  // Word i initially holds 32'h1000_0000 + i. Ack arrives after ram_wait
  // cycles of stb; ram_wait = 0 is a zero-wait slave.
  logic [31:0] mem [256];
  int ram_wait = 0;
  int wcnt     = 0;

  assign ram_ack  = r_stb & r_cyc & (wcnt >= ram_wait);
  assign ram_rdat = mem[r_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
  end

  always @(posedge clk) begin
    if (!(r_stb && r_cyc) || ram_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
    if (ram_ack && r_we) mem[r_addr] <= r_dat;
  end

  // ---------------- grant monitor ----------------
  // Records grant_o at the start of every rambus cycle.
  logic [0:0] obs_q[$];
  logic [0:0] exp_q[$];
  logic       prev_stb = 1'b0;

  always @(posedge clk) begin
    prev_stb <= r_stb;
    if (r_stb && !prev_stb) obs_q.push_back(grant);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic host_req(input logic we, input logic [31:0] addr, input logic [31:0] dat);
    h_stb = 1'b1; h_cyc = 1'b1; h_we = we; h_addr = addr; h_dat = dat; h_sel = 4'hF;
  endtask

  task automatic gen_req(input logic we, input logic [7:0] addr, input logic [31:0] dat);
    g_stb = 1'b1; g_cyc = 1'b1; g_we = we; g_addr = addr; g_dat = dat; g_sel = 4'hF;
  endtask

  task automatic host_idle();
    h_stb = 1'b0; h_cyc = 1'b0; h_we = 1'b0;
  endtask

  task automatic gen_idle();
    g_stb = 1'b0; g_cyc = 1'b0; g_we = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_h, n_g, base;
    rst_n = 1'b0;
    host_idle(); h_sel = 4'h0; h_dat = 32'h0; h_addr = 32'h0;
    gen_idle();  g_sel = 4'h0; g_dat = 32'h0; g_addr = 8'h0;

    // Reset values.
    tick(); tick();
    chk("rst_stb",   {31'h0, r_stb},  32'h0);
    chk("rst_cyc",   {31'h0, r_cyc},  32'h0);
    chk("rst_we",    {31'h0, r_we},   32'h0);
    chk("rst_sel",   {28'h0, r_sel},  32'hF);
    chk("rst_dat",   r_dat,           32'h0);
    chk("rst_addr",  {24'h0, r_addr}, 32'h0);
    chk("rst_grant", {31'h0, grant},  32'h0);
    chk("rst_acks",  {30'h0, h_ack, g_ack}, 32'h0);
    chk("rst_state", {30'h0, st},     {30'h0, S_IDLE});
    chk("rst_out",   {31'h0, r_rst},  32'h1);
    chk("rst_terr",  {31'h0, terr},   32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_rst_out", {31'h0, r_rst}, 32'h0);

    // Host write to 0x3000_1008, zero-wait RAM.
    host_req(1'b1, 32'h3000_1008, 32'hA5A5_0001);
    tick();
    chk("hw_stb",   {31'h0, r_stb},  32'h1);
    chk("hw_addr",  {24'h0, r_addr}, 32'd2);
    chk("hw_we",    {31'h0, r_we},   32'h1);
    chk("hw_wdat",  r_dat,           32'hA5A5_0001);
    chk("hw_grant", {31'h0, grant},  32'h1);
    chk("hw_ack_early", {31'h0, h_ack}, 32'h0);
    tick();
    chk("hw_ack",     {31'h0, h_ack}, 32'h1);
    chk("hw_gen_ack", {31'h0, g_ack}, 32'h0);
    chk("hw_stb_drop", {31'h0, r_stb}, 32'h0);
    chk("hw_rdat",    h_rdat,         32'h1000_0002);
    chk("hw_done",    {30'h0, st},    {30'h0, S_DONE});
    host_idle();
    tick();
    chk("hw_ack_pulse", {31'h0, h_ack}, 32'h0);
    chk("hw_idle",      {30'h0, st},    {30'h0, S_IDLE});

    // Host read-back of the written word.
    host_req(1'b0, 32'h3000_1008, 32'h0);
    tick(); tick();
    chk("hr_ack",  {31'h0, h_ack}, 32'h1);
    chk("hr_rdat", h_rdat,         32'hA5A5_0001);
    host_idle();
    tick();

    // Simultaneous requests right after reset: generator wins first.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    gen_req(1'b0, 8'd5, 32'h0);
    host_req(1'b0, 32'h3000_1010, 32'h0);
    tick();
    chk("tie_grant0", {31'h0, grant},  32'h0);
    chk("tie_addr0",  {24'h0, r_addr}, 32'd5);
    tick();
    chk("tie_gack",  {31'h0, g_ack}, 32'h1);
    chk("tie_hack0", {31'h0, h_ack}, 32'h0);
    chk("tie_gdat",  g_rdat,         32'h1000_0005);
    gen_idle();
    tick();
    chk("tie_no_ack", {30'h0, h_ack, g_ack}, 32'h0);
    tick();
    chk("tie_grant1", {31'h0, grant},  32'h1);
    chk("tie_addr1",  {24'h0, r_addr}, 32'd4);
    tick();
    chk("tie_hack",  {31'h0, h_ack}, 32'h1);
    chk("tie_gack0", {31'h0, g_ack}, 32'h0);
    chk("tie_hdat",  h_rdat,         32'h1000_0004);
    host_idle();
    tick(); tick();
    chk("tie_after", {30'h0, h_ack, g_ack}, 32'h0);

    // Both masters request continuously for six transactions.
    obs_q.delete();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gen_req(1'b0, 8'd7, 32'h0);
    host_req(1'b0, 32'h3000_1004, 32'h0);
    n_h = 0; n_g = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (h_ack) n_h++;
      if (g_ack) n_g++;
      if (n_h == 3) break;
    end
    gen_idle(); host_idle();
    tick(); tick(); tick();
    chk("alt_host_acks", n_h, 3);
    chk("alt_gen_acks",  n_g, 3);
    chk("alt_count",     obs_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_q.size()) chk($sformatf("alt_grant%0d", i), {31'h0, obs_q[i]}, {31'h0, exp_q[i]});
    end

    // Out-of-window host access: no RAM cycle and no ack.
    base = obs_q.size();
    n_h = 0;
    host_req(1'b0, 32'h3000_2000, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (h_ack) n_h++;
    end
    host_idle();
    tick();
    chk("oow_no_cycle", obs_q.size(), base);
    chk("oow_no_ack",   n_h, 0);
    chk("oow_idle",     {30'h0, st}, {30'h0, S_IDLE});

`ifdef RAMBUS_ARB_TIMEOUT_EN
    // RAM never acks: transaction ends after four BUSY cycles.
    ram_wait = 1000;
    gen_req(1'b0, 8'd9, 32'h0);
    tick();
    chk("to_busy", {30'h0, st}, {30'h0, S_BUSY});
    tick(); tick(); tick();
    chk("to_no_ack_yet", {31'h0, g_ack}, 32'h0);
    chk("to_terr_low",   {31'h0, terr},  32'h0);
    tick();
    chk("to_ack",  {31'h0, g_ack}, 32'h1);
    chk("to_dat",  g_rdat,         32'h0);
    chk("to_terr", {31'h0, terr},  32'h1);
    chk("to_stb",  {31'h0, r_stb}, 32'h0);
    gen_idle();
    tick(); tick(); tick();
    chk("to_sticky", {31'h0, terr}, 32'h1);
`else
    chk("terr_tied", {31'h0, terr}, 32'h0);
`endif

    // Reset while BUSY with a slow RAM aborts the transaction.
    ram_wait = 5;
    n_h = 0;
    host_req(1'b0, 32'h3000_1004, 32'h0);
    tick();
    chk("ab_busy", {30'h0, st}, {30'h0, S_BUSY});
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("ab_stb",   {31'h0, r_stb}, 32'h0);
    chk("ab_cyc",   {31'h0, r_cyc}, 32'h0);
    chk("ab_ack",   {31'h0, h_ack}, 32'h0);
    chk("ab_state", {30'h0, st},    {30'h0, S_IDLE});
    chk("ab_terr",  {31'h0, terr},  32'h0);
    rst_n = 1'b1;
    host_idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (h_ack) n_h++;
    end
    chk("ab_no_late_ack", n_h, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
